// File: rtl/bit_stream_decoder.sv
// bit_stream_decoder: USB receive-side packet decoder.
// Hunts for SYNC in the de-stuffed bit stream, deserialises the PID and
// payload LSB-first, checks PID complement and CRC5/CRC16, and reports
// each packet as a pkt_rcvd or rcv_err strobe.
// Optional feature: define RX_TIMEOUT_EN to drop a packet after
// TIMEOUT_CYCLES idle cycles (err_code 4).
// Output handshake: pkt_rcvd and rcv_err are registered single-cycle strobes,
// never high together, with no back-pressure; the consumer samples pkt_in or
// err_code in the strobe cycle. pkt_in and err_code hold between strobes.

package bit_stream_decoder_pkg;
  typedef struct packed {
    logic [7:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
  } pkt_t;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_PID     = 3'd1,
    ST_TOKEN   = 3'd2,
    ST_DATA    = 3'd3,
    ST_HSK     = 3'd4,
    ST_DISCARD = 3'd5
  } rx_state_t;

  localparam logic [2:0] ERR_PID     = 3'd1;
  localparam logic [2:0] ERR_CRC     = 3'd2;
  localparam logic [2:0] ERR_LEN     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
endpackage

module bit_stream_decoder
  import bit_stream_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_L,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       rcv_eop,
  output pkt_t       pkt_in,
  output logic       pkt_rcvd,
  output logic       rcv_err,
  output logic [2:0] err_code,
  output logic       rcv_busy
);

  // Time-ordered 0000_0001 seen through a shift register filled at the MSB.
  localparam logic [7:0]  SYNC_PATTERN = 8'h80;
  localparam logic [4:0]  CRC5_INIT    = 5'h1F;
  localparam logic [4:0]  CRC5_POLY    = 5'h05;
  localparam logic [4:0]  CRC5_GOOD    = 5'b01100;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY   = 16'h8005;
  localparam logic [15:0] CRC16_GOOD   = 16'h800D;

  rx_state_t   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [6:0]  bit_cnt_q, bit_cnt_d;
  logic [4:0]  crc5_q, crc5_d;
  logic [15:0] crc16_q, crc16_d;
  logic [63:0] payload_q, payload_d;
  logic [7:0]  pid_q, pid_d;
  logic [2:0]  pend_err_q, pend_err_d;
  pkt_t        pkt_q, pkt_d;
  logic        pkt_rcvd_q, pkt_rcvd_d;
  logic        rcv_err_q, rcv_err_d;
  logic [2:0]  err_code_q, err_code_d;

  logic        timeout_hit;
  logic        take_bit;
  logic [7:0]  shift_in;
  logic [6:0]  bit_cnt_inc;
  logic [6:0]  exp_len;
  logic [4:0]  crc5_nxt;
  logic [15:0] crc16_nxt;
  logic        close_err;
  logic        close_ok;
  logic [2:0]  close_code;

  // Classify a fully received PID byte into the payload state it selects.
  function automatic rx_state_t pid_to_state(input logic [7:0] p);
    rx_state_t s;
    s = ST_DISCARD;
    if (p[7:4] == ~p[3:0]) begin
      case (p[3:0])
        4'h1, 4'h9, 4'hD: s = ST_TOKEN;
        4'h3, 4'hB:       s = ST_DATA;
        4'h2, 4'hA, 4'hE: s = ST_HSK;
        default:          s = ST_DISCARD;
      endcase
    end
    return s;
  endfunction

`ifdef RX_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Idle counter: restarts on any line activity, runs only while a packet is open.
  always_comb begin
    to_cnt_d    = '0;
    timeout_hit = 1'b0;
    if (state_q != ST_HUNT && !bit_valid && !rcv_eop) begin
      if (to_cnt_q + TO_W'(1) == TO_W'(TIMEOUT_CYCLES)) begin
        timeout_hit = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  // No idle supervision in this build: a packet stays open until rcv_eop.
  assign timeout_hit = 1'b0;
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  // Next-state, datapath and strobe generation.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    crc5_d     = crc5_q;
    crc16_d    = crc16_q;
    payload_d  = payload_q;
    pid_d      = pid_q;
    pend_err_d = pend_err_q;
    pkt_d      = pkt_q;
    pkt_rcvd_d = 1'b0;
    rcv_err_d  = 1'b0;
    err_code_d = err_code_q;
    close_err  = 1'b0;
    close_ok   = 1'b0;
    close_code = '0;

    // rcv_eop wins over bit_valid in the same cycle.
    take_bit    = bit_valid & ~rcv_eop;
    shift_in    = {bit_in, shift_q[7:1]};
    bit_cnt_inc = (bit_cnt_q == 7'h7F) ? bit_cnt_q : bit_cnt_q + 7'd1;
    crc5_nxt    = {crc5_q[3:0], 1'b0} ^ ((crc5_q[4] ^ bit_in) ? CRC5_POLY : 5'h00);
    crc16_nxt   = {crc16_q[14:0], 1'b0} ^ ((crc16_q[15] ^ bit_in) ? CRC16_POLY : 16'h0000);

    case (state_q)
      ST_TOKEN: exp_len = 7'd16;
      ST_DATA:  exp_len = 7'd80;
      default:  exp_len = 7'd0;
    endcase

    case (state_q)
      ST_HUNT: begin
        // bit_cnt guards against a freshly cleared register counting as seven 0s.
        if (take_bit) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_inc;
          if (shift_in == SYNC_PATTERN && bit_cnt_q >= 7'd7) begin
            state_d   = ST_PID;
            shift_d   = '0;
            bit_cnt_d = '0;
          end
        end
      end
      ST_PID: begin
        if (rcv_eop) begin
          close_err  = 1'b1;
          close_code = ERR_LEN;
        end else if (take_bit) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_inc;
          if (bit_cnt_q == 7'd7) begin
            pid_d     = shift_in;
            bit_cnt_d = '0;
            crc5_d    = CRC5_INIT;
            crc16_d   = CRC16_INIT;
            state_d   = pid_to_state(shift_in);
            if (pid_to_state(shift_in) == ST_DISCARD) pend_err_d = ERR_PID;
          end
        end
      end
      ST_TOKEN, ST_DATA, ST_HSK: begin
        if (rcv_eop) begin
          if (bit_cnt_q != exp_len) begin
            close_err  = 1'b1;
            close_code = ERR_LEN;
          end else if ((state_q == ST_TOKEN && crc5_q != CRC5_GOOD) ||
                       (state_q == ST_DATA && crc16_q != CRC16_GOOD)) begin
            close_err  = 1'b1;
            close_code = ERR_CRC;
          end else begin
            close_ok = 1'b1;
          end
        end else if (take_bit) begin
          bit_cnt_d = bit_cnt_inc;
          crc5_d    = crc5_nxt;
          crc16_d   = crc16_nxt;
          if (!bit_cnt_q[6]) payload_d[bit_cnt_q[5:0]] = bit_in;
        end
      end
      ST_DISCARD: begin
        if (rcv_eop) begin
          close_err  = 1'b1;
          close_code = pend_err_q;
        end
      end
      default: state_d = ST_HUNT;
    endcase

    if (timeout_hit) begin
      close_err  = 1'b1;
      close_code = ERR_TIMEOUT;
    end

    if (close_err || close_ok) begin
      state_d   = ST_HUNT;
      shift_d   = '0;
      bit_cnt_d = '0;
    end

    if (close_err) begin
      rcv_err_d  = 1'b1;
      err_code_d = close_code;
    end

    // Fields the PID type does not carry are returned as zero.
    if (close_ok) begin
      pkt_rcvd_d = 1'b1;
      pkt_d      = '0;
      pkt_d.pid  = pid_q;
      if (state_q == ST_TOKEN) begin
        pkt_d.addr = payload_q[6:0];
        pkt_d.endp = payload_q[10:7];
      end
      if (state_q == ST_DATA) begin
        pkt_d.data = payload_q;
      end
    end
  end

  // State and datapath registers; reset aborts any open packet silently.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q    <= ST_HUNT;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      crc5_q     <= '0;
      crc16_q    <= '0;
      payload_q  <= '0;
      pid_q      <= '0;
      pend_err_q <= '0;
      pkt_q      <= '0;
      pkt_rcvd_q <= 1'b0;
      rcv_err_q  <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      crc5_q     <= crc5_d;
      crc16_q    <= crc16_d;
      payload_q  <= payload_d;
      pid_q      <= pid_d;
      pend_err_q <= pend_err_d;
      pkt_q      <= pkt_d;
      pkt_rcvd_q <= pkt_rcvd_d;
      rcv_err_q  <= rcv_err_d;
      err_code_q <= err_code_d;
    end
  end

  assign pkt_in   = pkt_q;
  assign pkt_rcvd = pkt_rcvd_q;
  assign rcv_err  = rcv_err_q;
  assign err_code = err_code_q;
  assign rcv_busy = (state_q != ST_HUNT);

endmodule

// File: tb/tb_bit_stream_decoder.sv
// Testbench for bit_stream_decoder: directed packets plus randomized
// frames, each checked against a packet-level reference model.
module tb_bit_stream_decoder;
  import bit_stream_decoder_pkg::*;

`ifdef RX_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 255;
`endif
  localparam int PW = $bits(pkt_t);
  localparam int EW = 1 + 3 + PW;

  logic       clk = 1'b0;
  logic       rst_L = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       rcv_eop = 1'b0;
  pkt_t       pkt_in;
  logic       pkt_rcvd;
  logic       rcv_err;
  logic [2:0] err_code;
  logic       rcv_busy;

  bit_stream_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_L     (rst_L),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .rcv_eop   (rcv_eop),
    .pkt_in    (pkt_in),
    .pkt_rcvd  (pkt_rcvd),
    .rcv_err   (rcv_err),
    .err_code  (err_code),
    .rcv_busy  (rcv_busy)
  );

  // ---------------- clock / cycle bookkeeping ----------------
  always #5 clk = ~clk;

  int   cyc = 0;
  int   last_valid_cyc = 0;
  logic eop_seen = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bit_valid) last_valid_cyc = cyc;
    eop_seen = rcv_eop;
  end

  // ---------------- scoreboard state ----------------
  int             n_tests = 0;
  int             n_fail = 0;
  logic [EW-1:0]  exp_q[$];
  logic [EW-1:0]  mon_e;
  pkt_t           last_good;
  logic [2:0]     last_err;
  bit             frame_q[$];

  logic [3:0] tok_n[3] = '{4'h1, 4'h9, 4'hD};
  logic [3:0] dat_n[2] = '{4'h3, 4'hB};
  logic [3:0] hsk_n[3] = '{4'h2, 4'hA, 4'hE};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // CRC as transmitted: remainder of the message, complemented, highest power first.
  function automatic logic [15:0] crc_tx(input int start, input int count, input int width);
    logic [15:0] rem;
    logic [15:0] poly;
    logic [15:0] out;
    logic        fb;
    rem  = (width == 5) ? 16'h001F : 16'hFFFF;
    poly = (width == 5) ? 16'h0005 : 16'h8005;
    for (int i = 0; i < count; i++) begin
      fb  = rem[width-1] ^ frame_q[start+i];
      rem = rem << 1;
      if (width == 5) rem = rem & 16'h001F;
      if (fb) rem = rem ^ poly;
    end
    out = '0;
    for (int j = 0; j < width; j++) out[j] = ~rem[width-1-j];
    return out;
  endfunction

  // -1 illegal, 0 token, 1 data, 2 handshake
  function automatic int classify(input logic [7:0] pid);
    if (pid[7:4] != ~pid[3:0]) return -1;
    foreach (tok_n[i]) if (pid[3:0] == tok_n[i]) return 0;
    foreach (dat_n[i]) if (pid[3:0] == dat_n[i]) return 1;
    foreach (hsk_n[i]) if (pid[3:0] == hsk_n[i]) return 2;
    return -1;
  endfunction

  function automatic logic [EW-1:0] mk_err(input logic [2:0] code);
    last_err = code;
    return {1'b1, code, last_good};
  endfunction

  // Expected outcome of the frame currently in frame_q (bits after SYNC).
  function automatic logic [EW-1:0] model_expect();
    logic [7:0]  pid;
    logic [15:0] c;
    pkt_t        p;
    logic        ok;
    int          n;
    int          kind;
    int          need;
    n   = frame_q.size();
    pid = '0;
    if (n < 8) return mk_err(3'd3);
    for (int i = 0; i < 8; i++) pid[i] = frame_q[i];
    kind = classify(pid);
    if (kind < 0) return mk_err(3'd1);
    need = (kind == 0) ? 16 : ((kind == 1) ? 80 : 0);
    if (n - 8 != need) return mk_err(3'd3);
    p     = '0;
    p.pid = pid;
    ok    = 1'b1;
    if (kind == 0) begin
      for (int i = 0; i < 7; i++) p.addr[i] = frame_q[8+i];
      for (int i = 0; i < 4; i++) p.endp[i] = frame_q[15+i];
      c = crc_tx(8, 11, 5);
      for (int j = 0; j < 5; j++) if (frame_q[19+j] != c[j]) ok = 1'b0;
    end
    if (kind == 1) begin
      for (int i = 0; i < 64; i++) p.data[i] = frame_q[8+i];
      c = crc_tx(8, 64, 16);
      for (int j = 0; j < 16; j++) if (frame_q[72+j] != c[j]) ok = 1'b0;
    end
    if (!ok) return mk_err(3'd2);
    last_good = p;
    return {1'b0, 3'd0, p};
  endfunction

  // ---------------- frame builders ----------------
  task automatic push_bits(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) frame_q.push_back(v[i]);
  endtask

  task automatic build_token(input logic [3:0] nib, input logic [6:0] addr, input logic [3:0] endp);
    logic [15:0] c;
    frame_q.delete();
    push_bits({56'd0, ~nib, nib}, 8);
    push_bits({57'd0, addr}, 7);
    push_bits({60'd0, endp}, 4);
    c = crc_tx(8, 11, 5);
    push_bits({48'd0, c}, 5);
  endtask

  task automatic build_data(input logic [3:0] nib, input logic [63:0] data);
    logic [15:0] c;
    frame_q.delete();
    push_bits({56'd0, ~nib, nib}, 8);
    push_bits(data, 64);
    c = crc_tx(8, 64, 16);
    push_bits({48'd0, c}, 16);
  endtask

  task automatic build_hsk(input logic [3:0] nib);
    frame_q.delete();
    push_bits({56'd0, ~nib, nib}, 8);
  endtask

  task automatic truncate(input int n);
    while (frame_q.size() > n) void'(frame_q.pop_back());
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic b, input logic v, input logic e);
    bit_in    = b;
    bit_valid = v;
    rcv_eop   = e;
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    rcv_eop   = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int n_stall, input bit rnd, input bit with_eop);
    int used;
    used = 0;
    for (int i = 0; i < 8; i++) drive(logic'(i == 7), 1'b1, 1'b0);
    for (int i = 0; i < frame_q.size(); i++) begin
      drive(frame_q[i], 1'b1, 1'b0);
      if ((used < n_stall && i % 13 == 6) || (rnd && $urandom_range(0, 5) == 0)) begin
        drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        used++;
      end
    end
    if (with_eop) drive(1'b0, 1'b0, 1'b1);
    go_idle();
  endtask

  task automatic issue(input int n_stall, input bit rnd);
    exp_q.push_back(model_expect());
    send_frame(n_stall, rnd, 1'b1);
  endtask

  // Idle J bits and stalls between frames; never forms SYNC.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    go_idle();
  endtask

  task automatic random_frame();
    int sel;
    int cor;
    int idx;
    sel = $urandom_range(0, 3);
    case (sel)
      0: build_token(tok_n[$urandom_range(0, 2)], 7'($urandom), 4'($urandom));
      1: build_data(dat_n[$urandom_range(0, 1)], {32'($urandom), 32'($urandom)});
      2: build_hsk(hsk_n[$urandom_range(0, 2)]);
      default: begin
        frame_q.delete();
        push_bits({32'd0, 32'($urandom)}, 8 + $urandom_range(0, 20));
      end
    endcase
    cor = $urandom_range(0, 7);
    if (cor == 0) begin
      idx = $urandom_range(0, frame_q.size() - 1);
      frame_q[idx] = !frame_q[idx];
    end else if (cor == 1) begin
      truncate(frame_q.size() - $urandom_range(1, 3));
    end else if (cor == 2) begin
      push_bits({32'd0, 32'($urandom)}, $urandom_range(1, 3));
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_L && (pkt_rcvd || rcv_err)) begin
      check("strobe_exclusive", {127'd0, pkt_rcvd & rcv_err}, 128'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: got pkt_rcvd=%0b rcv_err=%0b, expected no strobe", pkt_rcvd, rcv_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_kind", {127'd0, rcv_err}, {127'd0, mon_e[EW-1]});
        if (rcv_err) check("err_code", {125'd0, err_code}, {125'd0, mon_e[EW-2 -: 3]});
        check("pkt_in", {45'd0, pkt_in}, {45'd0, mon_e[PW-1:0]});
        if (mon_e[EW-2 -: 3] == 3'd4) check("timeout_latency", 128'(cyc - last_valid_cyc), 128'(TO));
        else check("close_latency", {127'd0, eop_seen}, 128'd1);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] rnd_data;
    go_idle();
    last_good = '0;
    last_err  = '0;
    rst_L     = 1'b0;
    wait_cycles(3);
    check("reset_pkt_in", {45'd0, pkt_in}, 128'd0);
    check("reset_pkt_rcvd", {127'd0, pkt_rcvd}, 128'd0);
    check("reset_rcv_err", {127'd0, rcv_err}, 128'd0);
    check("reset_err_code", {125'd0, err_code}, 128'd0);
    check("reset_busy", {127'd0, rcv_busy}, 128'd0);
    rst_L = 1'b1;
    wait_cycles(2);

    // OUT token addr 5 endp 4
    build_token(4'h1, 7'd5, 4'd4);
    issue(0, 1'b0);
    wait_cycles(2);

    // EOP while hunting produces nothing
    drive(1'b0, 1'b0, 1'b1);
    go_idle();
    wait_cycles(3);
    check("hunt_eop_busy", {127'd0, rcv_busy}, 128'd0);

    // DATA0 with five stalls
    build_data(4'h3, 64'hCAFEBABEDEADBEEF);
    issue(5, 1'b0);

    // ACK then NAK back-to-back
    build_hsk(4'h2);
    issue(0, 1'b0);
    build_hsk(4'hA);
    issue(0, 1'b0);
    wait_cycles(2);
    check("hsk_idle_busy", {127'd0, rcv_busy}, 128'd0);

    // Bad PID complement, then 16 bits
    frame_q.delete();
    push_bits(64'hE2, 8);
    push_bits({32'd0, 32'($urandom)}, 16);
    issue(0, 1'b0);

    // CRC16 error: data bit 17 flipped
    build_data(4'h3, 64'hCAFEBABEDEADBEEF);
    frame_q[8+17] = !frame_q[8+17];
    issue(0, 1'b0);

    // OUT cut after 12 payload bits
    build_token(4'h1, 7'd5, 4'd4);
    truncate(8 + 12);
    issue(0, 1'b0);

    // Lengths that a wrapping 7-bit counter would alias to a legal count
    build_data(4'hB, 64'h0123456789ABCDEF);
    push_bits({32'd0, 32'($urandom)}, 64);
    push_bits({32'd0, 32'($urandom)}, 64);
    issue(0, 1'b0);
    build_token(4'h9, 7'h7F, 4'hF);
    push_bits({32'd0, 32'($urandom)}, 64);
    push_bits({32'd0, 32'($urandom)}, 64);
    issue(0, 1'b0);

    // Reset in the middle of a DATA packet
    rnd_data = {32'($urandom), 32'($urandom)};
    build_data(4'h3, rnd_data);
    truncate(40);
    send_frame(0, 1'b0, 1'b0);
    rst_L = 1'b0;
    #2;
    check("midrst_pkt_in", {45'd0, pkt_in}, 128'd0);
    check("midrst_strobes", {126'd0, pkt_rcvd, rcv_err}, 128'd0);
    check("midrst_err_code", {125'd0, err_code}, 128'd0);
    check("midrst_busy", {127'd0, rcv_busy}, 128'd0);
    last_good = '0;
    last_err  = '0;
    wait_cycles(2);
    rst_L = 1'b1;
    wait_cycles(2);

    // Randomized frames
    for (int t = 0; t < 40; t++) begin
      random_frame();
      issue(0, 1'b1);
      idle_gap($urandom_range(0, 4));
    end

`ifdef RX_TIMEOUT_EN
    // Open packet with no further activity
    wait_cycles(3);
    build_token(4'h1, 7'd3, 4'd2);
    truncate(8 + 6);
    exp_q.push_back(mk_err(3'd4));
    send_frame(0, 1'b0, 1'b0);
    wait_cycles(TO + 5);
    check("timeout_busy", {127'd0, rcv_busy}, 128'd0);
`endif

    wait_cycles(5);
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    check("final_busy", {127'd0, rcv_busy}, 128'd0);
    check("err_code_held", {125'd0, err_code}, {125'd0, last_err});
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
